// File: rtl/packet_buffer_streamer_pkg.sv
// Shared types and helpers for the packet buffer streamer.
//   state_e  : streamer FSM states.
//   tkeep_f  : byte-enable mask for a beat given the tail byte count.
package packet_buffer_streamer_pkg;

  // Widest supported beat in bytes; tkeep_f returns this many bits.
  localparam int max_bytes_lp = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    DRAIN = 2'd2,
    ACK   = 2'd3
  } state_e;

  // tail == 0 means the beat is full (nbytes lanes enabled);
  // otherwise only the low 'tail' byte lanes are enabled.
  function automatic logic [max_bytes_lp-1:0] tkeep_f(input int unsigned tail,
                                                      input int unsigned nbytes);
    logic [max_bytes_lp-1:0] keep;
    keep = '0;
    for (int unsigned i = 0; i < max_bytes_lp; i++) begin
      keep[i] = (tail == 0) ? (i < nbytes) : (i < tail);
    end
    return keep;
  endfunction

endpackage

// File: rtl/packet_buffer_streamer_if.sv
// AXI-stream style beat channel between the streamer and the TX MAC.
//   tdata  : beat data, byte 0 in bits [7:0]
//   tkeep  : byte enables
//   tlast  : final beat of a packet
//   tvalid : beat valid (master)
//   tready : beat accepted (slave)
interface packet_buffer_streamer_if #(
  parameter int data_width_p = 64
) ();
  localparam int bytes_lp = data_width_p / 8;

  logic [data_width_p-1:0] tdata;
  logic [bytes_lp-1:0]     tkeep;
  logic                    tlast;
  logic                    tvalid;
  logic                    tready;

  modport master (output tdata, output tkeep, output tlast, output tvalid, input tready);
  modport slave  (input tdata, input tkeep, input tlast, input tvalid, output tready);
endinterface

// File: rtl/bsg_two_fifo.sv
// Two-entry FIFO with valid/ready enqueue and valid/yumi dequeue.
//   clk_i, reset_i : clock, synchronous active-high reset (pointers only)
//   v_i, data_i    : enqueue request and payload
//   ready_o        : space available
//   v_o, data_o    : head entry valid and payload
//   yumi_i         : consumer takes the head entry (only when v_o=1)
module bsg_two_fifo #(
  parameter int width_p = 8
) (
  input  logic               clk_i,
  input  logic               reset_i,
  output logic               ready_o,
  input  logic [width_p-1:0] data_i,
  input  logic               v_i,
  output logic               v_o,
  output logic [width_p-1:0] data_o,
  input  logic               yumi_i
);
  logic [width_p-1:0] mem_q [2];
  logic               wptr_q, rptr_q;
  logic [1:0]         cnt_q;
  logic               enq;

  assign ready_o = (cnt_q != 2'd2);
  assign v_o     = (cnt_q != 2'd0);
  assign data_o  = mem_q[rptr_q];
  assign enq     = v_i & ready_o;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      wptr_q <= 1'b0;
      rptr_q <= 1'b0;
      cnt_q  <= 2'd0;
    end else begin
      if (enq)    wptr_q <= ~wptr_q;
      if (yumi_i) rptr_q <= ~rptr_q;
      cnt_q <= cnt_q + 2'(enq) - 2'(yumi_i);
    end
  end

  // Storage is never reset; v_o qualifies it.
  always_ff @(posedge clk_i) begin
    if (enq) mem_q[wptr_q] <= data_i;
  end
endmodule

// File: rtl/packet_buffer_streamer.sv
// Drains one packet at a time from the packet buffer read port and streams
// it to the TX MAC, then pulses the slot-free ack.
//   clk_i, reset_i    : clock, synchronous active-high reset
//   packet_avail_i    : read slot holds a packet
//   packet_rsize_i    : packet byte count (stable while avail)
//   packet_ack_o      : one-cycle pulse freeing the slot
//   packet_rvalid_o   : word read request
//   packet_raddr_o    : word-aligned byte address of the read
//   packet_rdata_i    : read data, valid the cycle after the request
//   m_axis            : outgoing beat stream (master side)
module packet_buffer_streamer
  import packet_buffer_streamer_pkg::*;
#(
  parameter int data_width_p = 64,
  parameter int els_p        = 2048,
  localparam int bytes_lp      = data_width_p / 8,
  localparam int addr_width_lp = $clog2(els_p),
  localparam int size_width_lp = $clog2(els_p + 1)
) (
  input  logic                     clk_i,
  input  logic                     reset_i,
  input  logic                     packet_avail_i,
  output logic                     packet_ack_o,
  input  logic [size_width_lp-1:0] packet_rsize_i,
  output logic                     packet_rvalid_o,
  output logic [addr_width_lp-1:0] packet_raddr_o,
  input  logic [data_width_p-1:0]  packet_rdata_i,
  packet_buffer_streamer_if.master m_axis
);
  localparam int lg_bytes_lp   = $clog2(bytes_lp);
  localparam int fifo_width_lp = 1 + bytes_lp + data_width_p;

  if (!(data_width_p == 32 || data_width_p == 64)) begin : g_bad_width
    $error("packet_buffer_streamer: data_width_p must be 32 or 64");
  end

  state_e                    state_q, state_d;
  logic [addr_width_lp-1:0]  addr_q, addr_d;
  logic [size_width_lp-1:0]  words_left_q, words_left_d;
  logic [bytes_lp-1:0]       keep_last_q, keep_last_d;
  logic                      inflight_q, inflight_last_q;
  logic [1:0]                outst_q;   // reads issued whose beat is not yet accepted

  logic [size_width_lp:0]    size_pad;
  logic [size_width_lp-1:0]  nwords;
  logic [max_bytes_lp-1:0]   keep_full;
  logic                      issue, deq, last_word;

  logic                      fifo_ready_lo, fifo_v_lo;
  logic [bytes_lp-1:0]       keep_li;
  logic [fifo_width_lp-1:0]  fifo_data_li, fifo_data_lo;

  assign size_pad  = {1'b0, packet_rsize_i} + (size_width_lp + 1)'(bytes_lp - 1);
  assign nwords    = size_width_lp'(size_pad >> lg_bytes_lp);
  assign keep_full = tkeep_f(32'(packet_rsize_i[lg_bytes_lp-1:0]), bytes_lp);

  // Credit: at most two words may sit between issue and acceptance, which is
  // exactly the FIFO depth, so the FIFO can never overflow. A beat accepted
  // this cycle returns its credit immediately to keep 1 beat/cycle.
  assign deq       = fifo_v_lo & m_axis.tready;
  assign issue     = (state_q == READ) && ({1'b0, outst_q} < (3'd2 + 3'(deq)));
  assign last_word = (words_left_q == size_width_lp'(1));

  assign packet_rvalid_o = issue;
  assign packet_raddr_o  = addr_q;

  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    words_left_d = words_left_q;
    keep_last_d  = keep_last_q;
    packet_ack_o = 1'b0;
    case (state_q)
      IDLE: begin
        if (packet_avail_i) begin
          if (packet_rsize_i != '0) begin
            words_left_d = nwords;
            keep_last_d  = keep_full[bytes_lp-1:0];
            addr_d       = '0;
            state_d      = READ;
          end else begin
            state_d = ACK;
          end
        end
      end
      READ: begin
        if (issue) begin
          // After the final read the address naturally wraps to 0 at els_p.
          addr_d       = addr_q + addr_width_lp'(bytes_lp);
          words_left_d = words_left_q - size_width_lp'(1);
          if (last_word) state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (deq && m_axis.tlast) state_d = ACK;
      end
      ACK: begin
        packet_ack_o = 1'b1;
        state_d      = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q      <= IDLE;
      addr_q       <= '0;
      words_left_q <= '0;
      inflight_q   <= 1'b0;
      outst_q      <= 2'd0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      words_left_q <= words_left_d;
      inflight_q   <= issue;
      outst_q      <= outst_q + 2'(issue) - 2'(deq);
    end
  end

  always_ff @(posedge clk_i) begin
    keep_last_q     <= keep_last_d;
    inflight_last_q <= issue & last_word;
  end

  // Read data lands one cycle after issue and is queued with its sideband.
  assign keep_li      = inflight_last_q ? keep_last_q : '1;
  assign fifo_data_li = {inflight_last_q, keep_li, packet_rdata_i};

  bsg_two_fifo #(.width_p(fifo_width_lp)) u_out_fifo (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .ready_o (fifo_ready_lo),
    .data_i  (fifo_data_li),
    .v_i     (inflight_q),
    .v_o     (fifo_v_lo),
    .data_o  (fifo_data_lo),
    .yumi_i  (deq)
  );

  assign m_axis.tvalid = fifo_v_lo;
  assign m_axis.tdata  = fifo_data_lo[data_width_p-1:0];
  assign m_axis.tkeep  = fifo_data_lo[data_width_p +: bytes_lp];
  // Storage is unreset, so tlast is qualified to read 0 when nothing is valid.
  assign m_axis.tlast  = fifo_v_lo & fifo_data_lo[fifo_width_lp-1];

`ifndef SYNTHESIS
  always_ff @(posedge clk_i) begin
    if (!reset_i && (state_q == READ || state_q == DRAIN))
      assert (packet_avail_i) else $error("packet_avail_i dropped mid-packet");
    if (!reset_i && inflight_q)
      assert (fifo_ready_lo) else $error("output FIFO overflow");
  end
`endif
endmodule

// File: tb/tb_packet_buffer_streamer.sv
module tb_packet_buffer_streamer;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  // Buffer contents: byte at address a for packet seed s.
  function automatic logic [7:0] bb(input logic [7:0] s, input int a);
    int v;
    v = a + (a >>> 8) * 13;
    return v[7:0] ^ s;
  endfunction

  function automatic logic [63:0] word64(input logic [7:0] s, input int a);
    logic [63:0] w;
    for (int k = 0; k < 8; k++) w[8*k +: 8] = bb(s, a + k);
    return w;
  endfunction

  function automatic logic [31:0] word32(input logic [7:0] s, input int a);
    logic [31:0] w;
    for (int k = 0; k < 4; k++) w[8*k +: 8] = bb(s, a + k);
    return w;
  endfunction

  // ---------------- 64-bit instance ----------------
  logic        avail = 1'b0;
  logic [11:0] rsize = '0;
  logic        ack, rvalid;
  logic [10:0] raddr;
  logic [63:0] rdata;
  logic [7:0]  seed_g = 8'h00;
  packet_buffer_streamer_if #(.data_width_p(64)) ax ();

  packet_buffer_streamer #(.data_width_p(64), .els_p(2048)) dut (
    .clk_i(clk), .reset_i(rst),
    .packet_avail_i(avail), .packet_ack_o(ack), .packet_rsize_i(rsize),
    .packet_rvalid_o(rvalid), .packet_raddr_o(raddr), .packet_rdata_i(rdata),
    .m_axis(ax)
  );

  always @(posedge clk) rdata <= rvalid ? word64(seed_g, int'(raddr)) : {8{8'hEE}};

  // ---------------- 32-bit instance ----------------
  logic        avail32 = 1'b0;
  logic [11:0] rsize32 = '0;
  logic        ack32, rvalid32;
  logic [10:0] raddr32;
  logic [31:0] rdata32;
  packet_buffer_streamer_if #(.data_width_p(32)) ax32 ();

  packet_buffer_streamer #(.data_width_p(32), .els_p(2048)) dut32 (
    .clk_i(clk), .reset_i(rst),
    .packet_avail_i(avail32), .packet_ack_o(ack32), .packet_rsize_i(rsize32),
    .packet_rvalid_o(rvalid32), .packet_raddr_o(raddr32), .packet_rdata_i(rdata32),
    .m_axis(ax32)
  );

  always @(posedge clk) rdata32 <= rvalid32 ? word32(8'h5A, int'(raddr32)) : 32'hEEEEEEEE;

  // ---------------- tready driver ----------------
  int tr_mode = 0;
  int tr_cyc = 0;
  initial begin
    ax.tready = 1'b1;
    forever begin
      @(posedge clk); #1;
      if (tr_mode == 0) begin
        ax.tready = 1'b1;
        tr_cyc = 0;
      end else begin
        ax.tready = (tr_cyc >= 3 && tr_cyc < 23) ? 1'b0 : 1'($urandom_range(0, 1));
        tr_cyc++;
      end
    end
  end

  // ---------------- 64-bit monitor ----------------
  int rd_idx = 0, beat_idx = 0, outst = 0, exp_beats = 0;
  int first_cyc = 0, last_cyc = 0, n_ack = 0;
  logic [7:0]  exp_last_keep = 8'hFF;
  logic        prev_stall = 1'b0;
  logic [63:0] prev_data;
  logic [8:0]  prev_ctl;

  always @(negedge clk) begin
    if (rst) begin
      prev_stall = 1'b0;
    end else begin
      if (rvalid) begin
        chk("raddr", 64'(raddr), 64'(rd_idx * 8));
        chk("rd_range", 64'(rd_idx < exp_beats), 64'(1));
        rd_idx++;
        outst++;
      end
      if (prev_stall) begin
        chk("stall_tvalid", 64'(ax.tvalid), 64'(1));
        chk("stall_tdata", ax.tdata, prev_data);
        chk("stall_ctl", 64'({ax.tlast, ax.tkeep}), 64'(prev_ctl));
      end
      if (ax.tvalid && ax.tready) begin
        chk("tdata", ax.tdata, word64(seed_g, beat_idx * 8));
        chk("tkeep", 64'(ax.tkeep),
            64'((beat_idx == exp_beats - 1) ? exp_last_keep : 8'hFF));
        chk("tlast", 64'(ax.tlast), 64'(beat_idx == exp_beats - 1));
        if (beat_idx == 0) first_cyc = cyc;
        last_cyc = cyc;
        beat_idx++;
        outst--;
      end
      if (rvalid) chk("outstanding", 64'(outst <= 2), 64'(1));
      prev_stall = ax.tvalid && !ax.tready;
      prev_data  = ax.tdata;
      prev_ctl   = {ax.tlast, ax.tkeep};
      if (ack) n_ack++;
    end
  end

  // ---------------- 32-bit monitor ----------------
  int n32 = 0;
  logic [31:0] d32 [4];
  logic [3:0]  k32 [4];
  logic        l32 [4];
  always @(negedge clk) begin
    if (!rst && ax32.tvalid && ax32.tready) begin
      if (n32 < 4) begin
        d32[n32] = ax32.tdata;
        k32[n32] = ax32.tkeep;
        l32[n32] = ax32.tlast;
      end
      n32++;
    end
  end

  // Called just after a rising edge; returns just after the cycle following the ack.
  task automatic run_pkt(input string tag, input logic [11:0] size, input logic [7:0] seed,
                         input int nb, input logic [7:0] lk, input bit full_rate);
    int start, n0, t;
    rd_idx = 0; beat_idx = 0; outst = 0;
    exp_beats = nb; exp_last_keep = lk; seed_g = seed;
    n0 = n_ack;
    avail = 1'b1;
    rsize = size;
    start = cyc;
    t = 0;
    while (!ack && t < 5000) begin
      @(posedge clk); #1;
      t++;
    end
    chk({tag, "_ack_wait"}, 64'(t < 5000), 64'(1));
    avail = 1'b0;
    chk({tag, "_beats"}, 64'(beat_idx), 64'(nb));
    if (nb > 0) chk({tag, "_ack_lat"}, 64'(cyc - last_cyc), 64'(1));
    else        chk({tag, "_ack_lat"}, 64'(cyc - start), 64'(1));
    if (full_rate && nb > 0) begin
      chk({tag, "_first_lat"}, 64'(first_cyc - start), 64'(3));
      chk({tag, "_rate"}, 64'(last_cyc - first_cyc), 64'(nb - 1));
    end
    @(posedge clk); #1;
    chk({tag, "_ack_pulse"}, 64'(ack), 64'(0));
    chk({tag, "_ack_count"}, 64'(n_ack - n0), 64'(1));
    chk({tag, "_idle_tvalid"}, 64'(ax.tvalid), 64'(0));
  endtask

  initial begin
    int t, n0;
    ax32.tready = 1'b1;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ack", 64'(ack), 64'(0));
    chk("rst_rvalid", 64'(rvalid), 64'(0));
    chk("rst_tvalid", 64'(ax.tvalid), 64'(0));
    chk("rst_tlast", 64'(ax.tlast), 64'(0));
    chk("rst32_ack", 64'(ack32), 64'(0));
    chk("rst32_tvalid", 64'(ax32.tvalid), 64'(0));
    rst = 1'b0;
    @(posedge clk); #1;

    run_pkt("p64", 12'd64, 8'h11, 8, 8'hFF, 1'b1);
    run_pkt("p13", 12'd13, 8'h22, 2, 8'h1F, 1'b1);
    run_pkt("p0", 12'd0, 8'h33, 0, 8'h00, 1'b1);
    run_pkt("p8", 12'd8, 8'h44, 1, 8'hFF, 1'b1);

    tr_mode = 1;
    run_pkt("p60", 12'd60, 8'h55, 8, 8'h0F, 1'b0);
    tr_mode = 0;
    @(posedge clk); #1;

    n0 = n_ack;
    run_pkt("b2b_64", 12'd64, 8'h66, 8, 8'hFF, 1'b1);
    run_pkt("b2b_1", 12'd1, 8'h77, 1, 8'h01, 1'b1);
    run_pkt("b2b_2048", 12'd2048, 8'h88, 256, 8'hFF, 1'b1);
    chk("b2b_acks", 64'(n_ack - n0), 64'(3));

    // Reset in the middle of a packet, then let it restart from the top.
    rd_idx = 0; beat_idx = 0; outst = 0;
    exp_beats = 8; exp_last_keep = 8'hFF; seed_g = 8'h99;
    n0 = n_ack;
    avail = 1'b1;
    rsize = 12'd64;
    t = 0;
    while (beat_idx < 3 && t < 100) begin
      @(posedge clk); #1;
      t++;
    end
    chk("mid_wait", 64'(t < 100), 64'(1));
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("mid_tvalid", 64'(ax.tvalid), 64'(0));
    chk("mid_ack", 64'(ack), 64'(0));
    chk("mid_rvalid", 64'(rvalid), 64'(0));
    chk("mid_no_ack", 64'(n_ack - n0), 64'(0));
    run_pkt("restart", 12'd64, 8'h99, 8, 8'hFF, 1'b1);

    // 32-bit instance: 7 bytes -> two beats, last keeps three lanes.
    avail32 = 1'b1;
    rsize32 = 12'd7;
    t = 0;
    while (!ack32 && t < 100) begin
      @(posedge clk); #1;
      t++;
    end
    chk("w32_ack_wait", 64'(t < 100), 64'(1));
    avail32 = 1'b0;
    chk("w32_beats", 64'(n32), 64'(2));
    chk("w32_d0", 64'(d32[0]), 64'(word32(8'h5A, 0)));
    chk("w32_k0", 64'(k32[0]), 64'(4'hF));
    chk("w32_l0", 64'(l32[0]), 64'(0));
    chk("w32_d1", 64'(d32[1]), 64'(word32(8'h5A, 4)));
    chk("w32_k1", 64'(k32[1]), 64'(4'h7));
    chk("w32_l1", 64'(l32[1]), 64'(1));
    @(posedge clk); #1;

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/packet_buffer_streamer.md
Name: packet_buffer_streamer

Overview:
- Drains packets from the packet buffer's read port and presents each one as an AXI-stream-style word stream to the MAC TX datapath.
- Issues word reads, absorbs the buffer's 1-cycle synchronous read latency, and generates tkeep/tlast from the packet size.
- Pulses the slot-free ack once the final beat has been accepted.
- Sits between the packet buffer read side and the Ethernet TX MAC.

Parameters:
- data_width_p, 64, stream and buffer word width; only 32 or 64 supported (assert otherwise).
- els_p, 2048, bytes per buffer slot; must match the buffer instance.
- Derived: bytes_lp = data_width_p/8; addr_width_lp = $clog2(els_p); size_width_lp = $clog2(els_p+1).

Ports:
- clk_i  in  1  clock.
- reset_i  in  1  synchronous, active-high reset.
- packet_avail_i  in  1  read slot holds a packet.
- packet_ack_o  out  1  one-cycle pulse that frees the read slot.
- packet_rsize_i  in  size_width_lp  packet byte count; stable while packet_avail_i=1.
- packet_rvalid_o  out  1  word read request.
- packet_raddr_o  out  addr_width_lp  byte address of the read; always word aligned.
- packet_rdata_i  in  data_width_p  read data, valid the cycle after packet_rvalid_o.
- m_axis_tdata_o  out  data_width_p  stream data; byte 0 in bits [7:0].
- m_axis_tkeep_o  out  bytes_lp  byte enables.
- m_axis_tlast_o  out  1  final beat of the packet.
- m_axis_tvalid_o  out  1  beat valid.
- m_axis_tready_i  in  1  sink accepts the beat.

Behaviour:
- Reset: state=IDLE, read address=0, in-flight=0, output FIFO emptied. packet_ack_o, packet_rvalid_o, m_axis_tvalid_o, m_axis_tlast_o all 0.
- Word count: nwords = ceil(rsize/bytes_lp), latched on leaving IDLE.
- Last-beat tkeep: tail = rsize mod bytes_lp. tkeep = (1<<tail)-1 when tail≠0, else all ones. All other beats: tkeep all ones.
- IDLE:
  - packet_avail_i=1 and rsize≠0: latch size, set address=0, go to READ.
  - packet_avail_i=1 and rsize=0: go to ACK; no beats are emitted.
- READ:
  - packet_rvalid_o=1 exactly when credit>0.
  - credit = 2 − (fifo_count + inflight) + (tvalid & tready this cycle).
  - Each issued read adds bytes_lp to the address.
  - After the read for word nwords−1 is issued: go to DRAIN.
- Data capture: the in-flight bit is set on the issue cycle. The next cycle, packet_rdata_i is enqueued into a 2-entry output FIFO together with the computed tkeep and tlast.
- Throughput: 1 beat/cycle when tready is held high. First tvalid appears 2 cycles after leaving IDLE.
- DRAIN: no new reads. The beat with tlast accepted (tvalid & tready & tlast) moves the FSM to ACK.
- ACK: packet_ack_o=1 for exactly one cycle, then IDLE. The next packet cannot start before the cycle after the ack.
- AXI rules:
  - tdata/tkeep/tlast stay stable while tvalid=1 and tready=0.
  - tvalid never drops without a handshake.
  - tready may be low indefinitely. The FIFO never overflows; enforced by credit.
- Max size: rsize=els_p gives nwords=els_p/bytes_lp. The address wraps to 0 only after the last read, and no read is issued past the end of the slot.
- packet_avail_i falling mid-packet is illegal (assert, translate_off region).
- Reset mid-packet: everything returns to the reset state the next cycle. No ack is issued; the slot is left to the buffer's own reset.

Decomposition:
- Shared package (ethernet controller pkg): streamer state enum {IDLE, READ, DRAIN, ACK} and a function computing tkeep from the tail byte count.
- One sub-module: a 2-entry output FIFO of {tlast, tkeep, tdata}, instantiated as bsg_two_fifo. No new module is needed.
- The credit counter and address counter live in the top.

Test Plan:
- 64-bit, rsize=64, tready=1 → 8 beats on consecutive cycles at raddr 0,8,…,56. tkeep=0xFF on all; tlast on beat 8. packet_ack_o pulses 1 cycle after beat 8 is accepted.
- rsize=13 → 2 beats. Beat 2 has tkeep=0x1F and tlast=1. Data matches bytes preloaded into the buffer; ack follows.
- rsize=0 with avail=1 → no tvalid, ack pulse 1 cycle later. A second packet (rsize=8) then streams 1 beat with tkeep=0xFF.
- rsize=60, tready toggled randomly (incl. 20-cycle low stretch) → 8 beats, in order, no loss or duplication, outputs stable while stalled, never more than 2 beats outstanding, tkeep=0x0F on the last beat.
- Back-to-back: 3 packets (sizes 64, 1, 2048) → 8, 1 and 256 beats; raddr restarts at 0 for each; exactly 3 ack pulses.
- Reset asserted mid-packet at beat 3 of 8 → tvalid=0 and no ack the next cycle. Restarted packet streams from raddr=0.
- data_width_p=32, rsize=7 → 2 beats, last tkeep=0x7.
